// File: rtl/scoreboarded_register_file_pkg.sv
// Defaults and address helpers shared by the register file, the hazard unit and decode.
package scoreboarded_register_file_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 32;
    localparam int DEFAULT_REGISTER_COUNT = 32;
    localparam int DEFAULT_READ_PORTS     = 2;
    localparam int DEFAULT_PENDING_BITS   = 2;
    localparam int ZERO_REGISTER_INDEX    = 0;

    // With a non-power-of-two register count, the top address codes select no register.
    function automatic logic address_is_valid(input int address, input int register_count);
        return address < register_count;
    endfunction

endpackage

// File: rtl/pending_counter.sv
// Per-register count of issued-but-not-written-back instructions; saturates at both ends.
module pending_counter
    import scoreboarded_register_file_pkg::*;
#(
    parameter int WIDTH = DEFAULT_PENDING_BITS
) (
    input  logic             system_clock,
    input  logic             system_reset,
    input  logic             increment,
    input  logic             decrement,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             full,
    output logic             nonzero
);

    assign full    = (count == '1);
    assign nonzero = (count != '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge system_clock) begin
        if (system_reset || clear) begin
            count <= '0;
        end else if (increment && !decrement && !full) begin
            count <= count + WIDTH'(1);
        end else if (decrement && !increment && nonzero) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/scoreboarded_register_file.sv
// Multi-port register file with same-cycle write bypass and a per-register pending-write scoreboard.
module scoreboarded_register_file
    import scoreboarded_register_file_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int REGISTER_COUNT = DEFAULT_REGISTER_COUNT,
    parameter int ADDRESS_SIZE   = $clog2(REGISTER_COUNT),
    parameter int READ_PORTS     = DEFAULT_READ_PORTS,
    parameter int PENDING_BITS   = DEFAULT_PENDING_BITS,
    parameter int ZERO_REGISTER  = 1
) (
    input  logic                               system_clock,
    input  logic                               system_reset,
    input  logic                               write_enable,
    input  logic [ADDRESS_SIZE-1:0]            write_address,
    input  logic [DATA_WIDTH-1:0]              write_data,
    input  logic [READ_PORTS*ADDRESS_SIZE-1:0] read_address,
    output logic [READ_PORTS*DATA_WIDTH-1:0]   read_data,
    output logic [READ_PORTS-1:0]              read_pending,
    input  logic                               reserve_enable,
    input  logic [ADDRESS_SIZE-1:0]            reserve_address,
    output logic                               reserve_ready,
    input  logic                               flush,
    output logic                               any_pending
);

    logic [DATA_WIDTH-1:0]   registers [REGISTER_COUNT];
    logic [PENDING_BITS-1:0] counts    [REGISTER_COUNT];
    logic [REGISTER_COUNT-1:0] full;
    logic [REGISTER_COUNT-1:0] nonzero;

    logic write_qualifies;
    logic reserve_qualifies;
    logic reserve_write_collide;
    logic reserve_accepted;

    // A register that can hold data and be tracked: in range and not the hardwired zero.
    function automatic logic target_allowed(input logic [ADDRESS_SIZE-1:0] address);
        return address_is_valid(int'(address), REGISTER_COUNT) &&
               !(ZERO_REGISTER != 0 && address == ADDRESS_SIZE'(ZERO_REGISTER_INDEX));
    endfunction

    assign write_qualifies       = write_enable && target_allowed(write_address);
    assign reserve_qualifies     = target_allowed(reserve_address);
    assign reserve_write_collide = write_qualifies && (write_address == reserve_address);

    // A writeback to a full register frees a slot in the same cycle, so the reserve may proceed.
    assign reserve_ready    = !reserve_qualifies || !full[reserve_address] || reserve_write_collide;
    assign reserve_accepted = reserve_enable && reserve_ready && reserve_qualifies && !flush;
    assign any_pending      = |nonzero;

    // NOTE: every entry is reset because reads must return 0 after reset; this keeps the array in flops.
    always_ff @(posedge system_clock) begin
        if (system_reset) begin
            for (int r = 0; r < REGISTER_COUNT; r++) begin
                registers[r] <= '0;
            end
        end else if (write_qualifies) begin
            registers[write_address] <= write_data;
        end
    end

    for (genvar r = 0; r < REGISTER_COUNT; r++) begin : g_counter
        pending_counter #(
            .WIDTH(PENDING_BITS)
        ) u_counter (
            .system_clock(system_clock),
            .system_reset(system_reset),
            .increment   (reserve_accepted && (reserve_address == ADDRESS_SIZE'(r))),
            .decrement   (write_qualifies && (write_address == ADDRESS_SIZE'(r))),
            .clear       (flush),
            .count       (counts[r]),
            .full        (full[r]),
            .nonzero     (nonzero[r])
        );
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
        logic [ADDRESS_SIZE-1:0] address;
        logic                    allowed;
        logic                    bypass;

        assign address = read_address[p*ADDRESS_SIZE +: ADDRESS_SIZE];
        assign allowed = target_allowed(address);
        assign bypass  = write_qualifies && (write_address == address);

        assign read_data[p*DATA_WIDTH +: DATA_WIDTH] =
            !allowed ? '0 : (bypass ? write_data : registers[address]);

        // The retiring write counts as already done; a same-cycle reserve is younger and ignored.
        assign read_pending[p] =
            allowed && nonzero[address] && !(bypass && counts[address] == PENDING_BITS'(1));
    end

endmodule

// File: tb/tb_scoreboarded_register_file.sv
// Directed bench: default 32x2-port instance plus a 24-register, 3-port instance.
module tb_scoreboarded_register_file;

    logic system_clock = 1'b0;
    logic system_reset;

    always #5 system_clock = ~system_clock;

    logic        a_write_enable;
    logic [4:0]  a_write_address;
    logic [31:0] a_write_data;
    logic [9:0]  a_read_address;
    logic [63:0] a_read_data;
    logic [1:0]  a_read_pending;
    logic        a_reserve_enable;
    logic [4:0]  a_reserve_address;
    logic        a_reserve_ready;
    logic        a_flush;
    logic        a_any_pending;

    logic        b_write_enable;
    logic [4:0]  b_write_address;
    logic [31:0] b_write_data;
    logic [14:0] b_read_address;
    logic [95:0] b_read_data;
    logic [2:0]  b_read_pending;
    logic        b_reserve_enable;
    logic [4:0]  b_reserve_address;
    logic        b_reserve_ready;
    logic        b_flush;
    logic        b_any_pending;

    int error_count = 0;
    int check_count = 0;

    scoreboarded_register_file u_dut_a (
        .system_clock   (system_clock),
        .system_reset   (system_reset),
        .write_enable   (a_write_enable),
        .write_address  (a_write_address),
        .write_data     (a_write_data),
        .read_address   (a_read_address),
        .read_data      (a_read_data),
        .read_pending   (a_read_pending),
        .reserve_enable (a_reserve_enable),
        .reserve_address(a_reserve_address),
        .reserve_ready  (a_reserve_ready),
        .flush          (a_flush),
        .any_pending    (a_any_pending)
    );

    scoreboarded_register_file #(
        .REGISTER_COUNT(24),
        .READ_PORTS    (3)
    ) u_dut_b (
        .system_clock   (system_clock),
        .system_reset   (system_reset),
        .write_enable   (b_write_enable),
        .write_address  (b_write_address),
        .write_data     (b_write_data),
        .read_address   (b_read_address),
        .read_data      (b_read_data),
        .read_pending   (b_read_pending),
        .reserve_enable (b_reserve_enable),
        .reserve_address(b_reserve_address),
        .reserve_ready  (b_reserve_ready),
        .flush          (b_flush),
        .any_pending    (b_any_pending)
    );

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled 1ns later, well before the next edge.
    task automatic tick();
        @(posedge system_clock);
        #1;
    endtask

    task automatic idle_all();
        a_write_enable = 1'b0; a_write_address = '0; a_write_data = '0;
        a_reserve_enable = 1'b0; a_reserve_address = '0; a_flush = 1'b0;
        b_write_enable = 1'b0; b_write_address = '0; b_write_data = '0;
        b_reserve_enable = 1'b0; b_reserve_address = '0; b_flush = 1'b0;
    endtask

    initial begin
        // NOTE: bench drives inputs with blocking assignments; the DUT samples them on the next edge.
        system_reset = 1'b1;
        idle_all();
        a_read_address = '0;
        b_read_address = '0;
        tick();
        tick();
        system_reset = 1'b0;

        // Preload, then reset clears data and reservations.
        a_write_enable = 1'b1; a_write_address = 5'd1; a_write_data = 32'h11;
        a_reserve_enable = 1'b1; a_reserve_address = 5'd4;
        tick();
        idle_all();
        a_read_address = {5'd0, 5'd1};
        #1;
        check("preload_r1", a_read_data[31:0], 32'h11);
        check("preload_any_pending", a_any_pending, 1);
        system_reset = 1'b1;
        tick();
        system_reset = 1'b0;
        for (int r = 0; r < 32; r += 2) begin
            a_read_address = {5'(r + 1), 5'(r)};
            #1;
            check($sformatf("reset_read_r%0d", r), a_read_data[31:0], 0);
            check($sformatf("reset_read_r%0d", r + 1), a_read_data[63:32], 0);
            check($sformatf("reset_pending_r%0d", r), a_read_pending, 0);
        end
        a_reserve_address = 5'd4;
        #1;
        check("reset_any_pending", a_any_pending, 0);
        check("reset_reserve_ready", a_reserve_ready, 1);

        // Bypass and the hardwired zero register.
        tick();
        a_write_enable = 1'b1; a_write_address = 5'd5; a_write_data = 32'hDEADBEEF;
        a_read_address = {5'd0, 5'd5};
        #1;
        check("bypass_r5", a_read_data[31:0], 32'hDEADBEEF);
        check("r0_reads_zero", a_read_data[63:32], 0);
        tick();
        a_write_enable = 1'b0;
        #1;
        check("stored_r5", a_read_data[31:0], 32'hDEADBEEF);
        a_write_enable = 1'b1; a_write_address = 5'd0; a_write_data = 32'hFFFFFFFF;
        a_read_address = {5'd5, 5'd0};
        #1;
        check("r0_no_bypass", a_read_data[31:0], 0);
        check("r0_reserve_ready", a_reserve_ready, 1);
        tick();
        a_write_enable = 1'b0;
        #1;
        check("r0_after_write", a_read_data[31:0], 0);
        check("r5_kept", a_read_data[63:32], 32'hDEADBEEF);

        // Pending lifecycle on r7.
        a_reserve_enable = 1'b1; a_reserve_address = 5'd7;
        a_read_address = {5'd0, 5'd7};
        #1;
        check("r7_pending_same_cycle_reserve", a_read_pending[0], 0);
        tick();
        a_reserve_enable = 1'b0;
        #1;
        check("r7_pending", a_read_pending[0], 1);
        check("r7_any_pending", a_any_pending, 1);
        a_write_enable = 1'b1; a_write_address = 5'd7; a_write_data = 32'hA5A5A5A5;
        #1;
        check("r7_pending_at_writeback", a_read_pending[0], 0);
        check("r7_bypass_at_writeback", a_read_data[31:0], 32'hA5A5A5A5);
        tick();
        a_write_enable = 1'b0;
        #1;
        check("r7_released", a_any_pending, 0);
        check("r7_stored", a_read_data[31:0], 32'hA5A5A5A5);

        // Saturation on r3.
        a_reserve_enable = 1'b1; a_reserve_address = 5'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("r3_ready_before_reserve%0d", i), a_reserve_ready, 1);
            tick();
        end
        check("r3_full_ready", a_reserve_ready, 0);
        tick();
        a_write_enable = 1'b1; a_write_address = 5'd3; a_write_data = 32'h33;
        #1;
        check("r3_ready_with_write", a_reserve_ready, 1);
        tick();
        idle_all();
        a_read_address = {5'd3, 5'd0};
        for (int i = 0; i < 3; i++) begin
            a_write_enable = 1'b1; a_write_address = 5'd3; a_write_data = 32'h300 + 32'(i);
            #1;
            check($sformatf("r3_pending_write%0d", i), a_read_pending[1], (i < 2) ? 1 : 0);
            check($sformatf("r3_bypass_write%0d", i), a_read_data[63:32], 32'h300 + 32'(i));
            tick();
        end
        a_write_enable = 1'b0;
        #1;
        check("r3_drained", a_any_pending, 0);

        // Flush beats a same-cycle reserve but not the data write.
        a_reserve_enable = 1'b1; a_reserve_address = 5'd9;
        tick();
        tick();
        a_flush = 1'b1;
        a_write_enable = 1'b1; a_write_address = 5'd9; a_write_data = 32'h12;
        tick();
        idle_all();
        a_read_address = {5'd0, 5'd9};
        a_reserve_address = 5'd9;
        #1;
        check("flush_r9_data", a_read_data[31:0], 32'h12);
        check("flush_r9_pending", a_read_pending[0], 0);
        check("flush_any_pending", a_any_pending, 0);

        // 24-register, 3-port instance: out-of-range address and independent bypass.
        b_write_enable = 1'b1; b_write_address = 5'd21; b_write_data = 32'h21;
        tick();
        b_write_address = 5'd23; b_write_data = 32'h23;
        tick();
        b_write_address = 5'd30; b_write_data = 32'h30;
        b_reserve_enable = 1'b1; b_reserve_address = 5'd30;
        b_read_address = {5'd6, 5'd14, 5'd30};
        #1;
        check("b_invalid_no_bypass", b_read_data[31:0], 0);
        check("b_invalid_reserve_ready", b_reserve_ready, 1);
        tick();
        idle_all();
        #1;
        check("b_invalid_reads_zero", b_read_data[31:0], 0);
        check("b_no_alias_r14", b_read_data[63:32], 0);
        check("b_no_alias_r6", b_read_data[95:64], 0);
        check("b_invalid_not_pending", b_any_pending, 0);
        b_write_enable = 1'b1; b_write_address = 5'd20; b_write_data = 32'hCAFE;
        b_read_address = {5'd20, 5'd21, 5'd20};
        #1;
        check("b_port0_bypass", b_read_data[31:0], 32'hCAFE);
        check("b_port1_stored", b_read_data[63:32], 32'h21);
        check("b_port2_bypass", b_read_data[95:64], 32'hCAFE);
        tick();
        b_write_address = 5'd21; b_write_data = 32'hBEEF;
        b_read_address = {5'd23, 5'd20, 5'd21};
        #1;
        check("b_port0_bypass_r21", b_read_data[31:0], 32'hBEEF);
        check("b_port1_stored_r20", b_read_data[63:32], 32'hCAFE);
        check("b_port2_stored_r23", b_read_data[95:64], 32'h23);
        tick();
        idle_all();
        b_reserve_enable = 1'b1; b_reserve_address = 5'd23;
        tick();
        b_reserve_enable = 1'b0;
        b_read_address = {5'd23, 5'd0, 5'd20};
        #1;
        check("b_port2_pending", b_read_pending, 3'b100);
        check("b_any_pending", b_any_pending, 1);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
